// File: rtl/xadc_avg_pkg.sv
// Shared widths and exponent helpers for the XADC boxcar averager.
package xadc_avg_pkg;

    localparam int XADC_DW       = 12;
    localparam int XADC_LOG2_MAX = 7;
    localparam int XADC_ACC_W    = XADC_DW + XADC_LOG2_MAX;

    typedef logic [2:0] avg_exp_t;

    function automatic avg_exp_t clamp_exp(input avg_exp_t req, input int unsigned lmax);
        return (32'(req) > lmax) ? avg_exp_t'(lmax) : req;
    endfunction

endpackage

// File: rtl/xadc_avg_chan.sv
// One XADC channel: strobe edge detect, 2^N boxcar average, optional min/max
// (enabled by XADC_AVG_MINMAX_EN).
module xadc_avg_chan
    import xadc_avg_pkg::*;
#(
    parameter int DW       = XADC_DW,
    parameter int LOG2_MAX = XADC_LOG2_MAX
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [DW-1:0] sample_i,
    input  logic          strobe_i,
    input  avg_exp_t      avg_log2_i,
    input  logic          clear_i,
    output logic [DW-1:0] avg_o,
    output logic          valid_o,
    output logic [DW-1:0] min_o,
    output logic [DW-1:0] max_o
);

    localparam int ACC_W = DW + LOG2_MAX;
    typedef logic [LOG2_MAX-1:0] cnt_t;

    logic              strobe_q, strobe_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    cnt_t              cnt_q, cnt_d;
    avg_exp_t          n_q, n_d;
    logic [DW-1:0]     avg_q, avg_d;
    logic              valid_q, valid_d;

    logic              sample_evt;
    logic              last;
    avg_exp_t          n_win;
    logic [ACC_W-1:0]  sum;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        strobe_d = strobe_i;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        avg_d    = avg_q;
        valid_d  = 1'b0;

        sample_evt = strobe_i & ~strobe_q;
        // The exponent is only sampled at the start of a window.
        n_win = (cnt_q == '0) ? clamp_exp(avg_log2_i, LOG2_MAX) : n_q;
        sum   = acc_q + ACC_W'(sample_i);
        last  = (cnt_q == cnt_t'((32'd1 << n_win) - 32'd1));

        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (sample_evt) begin
            n_d = n_win;
            if (last) begin
                avg_d   = DW'(sum >> n_win);
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            strobe_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            n_q      <= '0;
            avg_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            strobe_q <= strobe_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            avg_q    <= avg_d;
            valid_q  <= valid_d;
        end
    end

    assign avg_o   = avg_q;
    assign valid_o = valid_q;

`ifdef XADC_AVG_MINMAX_EN
    logic [DW-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
    logic [DW-1:0] min_q, min_d, max_q, max_d;
    logic [DW-1:0] lo, hi;

    always_comb begin
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        min_d     = min_q;
        max_d     = max_q;
        // First sample of a window seeds both extremes.
        lo = (cnt_q == '0 || sample_i < run_min_q) ? sample_i : run_min_q;
        hi = (cnt_q == '0 || sample_i > run_max_q) ? sample_i : run_max_q;

        if (clear_i) begin
            run_min_d = '0;
            run_max_d = '0;
        end else if (sample_evt) begin
            run_min_d = lo;
            run_max_d = hi;
            if (last) begin
                min_d = lo;
                max_d = hi;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            run_min_q <= '0;
            run_max_q <= '0;
            min_q     <= '0;
            max_q     <= '0;
        end else begin
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            min_q     <= min_d;
            max_q     <= max_d;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;
`else
    assign min_o = '0;
    assign max_o = '0;
`endif

endmodule

// File: rtl/xadc_avg.sv
// XADC channel A/B averager top: two independent channels sharing clear and
// exponent. Per-window min/max outputs are live only with XADC_AVG_MINMAX_EN.
module xadc_avg
    import xadc_avg_pkg::*;
#(
    parameter int DW       = XADC_DW,
    parameter int LOG2_MAX = XADC_LOG2_MAX
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [DW-1:0] xadc_a_i,
    input  logic [DW-1:0] xadc_b_i,
    input  logic          xadc_a_strobe_i,
    input  logic          xadc_b_strobe_i,
    input  logic [2:0]    avg_log2_i,
    input  logic          clear_i,
    output logic [DW-1:0] avg_a_o,
    output logic [DW-1:0] avg_b_o,
    output logic          avg_a_valid_o,
    output logic          avg_b_valid_o,
    output logic [DW-1:0] min_a_o,
    output logic [DW-1:0] max_a_o,
    output logic [DW-1:0] min_b_o,
    output logic [DW-1:0] max_b_o
);

    xadc_avg_chan #(.DW(DW), .LOG2_MAX(LOG2_MAX)) u_chan_a (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .sample_i   (xadc_a_i),
        .strobe_i   (xadc_a_strobe_i),
        .avg_log2_i (avg_log2_i),
        .clear_i    (clear_i),
        .avg_o      (avg_a_o),
        .valid_o    (avg_a_valid_o),
        .min_o      (min_a_o),
        .max_o      (max_a_o)
    );

    xadc_avg_chan #(.DW(DW), .LOG2_MAX(LOG2_MAX)) u_chan_b (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .sample_i   (xadc_b_i),
        .strobe_i   (xadc_b_strobe_i),
        .avg_log2_i (avg_log2_i),
        .clear_i    (clear_i),
        .avg_o      (avg_b_o),
        .valid_o    (avg_b_valid_o),
        .min_o      (min_b_o),
        .max_o      (max_b_o)
    );

endmodule

// File: tb/tb_xadc_avg.sv
// Self-checking bench for xadc_avg: vector table, directed corner sequences,
// and randomized traffic against a sample-list reference model.
module tb_xadc_avg;
    import xadc_avg_pkg::*;

    localparam int DW = XADC_DW;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic [DW-1:0] xadc_a_i, xadc_b_i;
    logic          xadc_a_strobe_i, xadc_b_strobe_i;
    logic [2:0]    avg_log2_i;
    logic          clear_i;
    logic [DW-1:0] avg_a_o, avg_b_o;
    logic          avg_a_valid_o, avg_b_valid_o;
    logic [DW-1:0] min_a_o, max_a_o, min_b_o, max_b_o;

    xadc_avg dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .xadc_a_i        (xadc_a_i),
        .xadc_b_i        (xadc_b_i),
        .xadc_a_strobe_i (xadc_a_strobe_i),
        .xadc_b_strobe_i (xadc_b_strobe_i),
        .avg_log2_i      (avg_log2_i),
        .clear_i         (clear_i),
        .avg_a_o         (avg_a_o),
        .avg_b_o         (avg_b_o),
        .avg_a_valid_o   (avg_a_valid_o),
        .avg_b_valid_o   (avg_b_valid_o),
        .min_a_o         (min_a_o),
        .max_a_o         (max_a_o),
        .min_b_o         (min_b_o),
        .max_b_o         (max_b_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: keeps the literal list of window samples per channel.
    int prev_stb [2];
    int win_len  [2];
    int win_n    [2];
    int win_smp  [2][128];
    int m_avg    [2];
    int m_min    [2];
    int m_max    [2];
    int m_valid  [2];

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            prev_stb[ch] = 0;
            win_len[ch]  = 0;
            win_n[ch]    = 0;
            m_avg[ch]    = 0;
            m_min[ch]    = 0;
            m_max[ch]    = 0;
            m_valid[ch]  = 0;
        end
    endtask

    task automatic model_step();
        int stb [2];
        int smp [2];
        int evt, sum, lo, hi, req;
        stb[0] = int'(xadc_a_strobe_i);
        stb[1] = int'(xadc_b_strobe_i);
        smp[0] = int'(xadc_a_i);
        smp[1] = int'(xadc_b_i);
        req = int'(avg_log2_i);
        for (int ch = 0; ch < 2; ch++) begin
            evt = (stb[ch] == 1 && prev_stb[ch] == 0) ? 1 : 0;
            prev_stb[ch] = stb[ch];
            m_valid[ch]  = 0;
            if (clear_i) begin
                win_len[ch] = 0;
            end else if (evt == 1) begin
                if (win_len[ch] == 0)
                    win_n[ch] = (req > XADC_LOG2_MAX) ? XADC_LOG2_MAX : req;
                win_smp[ch][win_len[ch]] = smp[ch];
                win_len[ch]++;
                if (win_len[ch] == (1 << win_n[ch])) begin
                    sum = 0;
                    lo  = win_smp[ch][0];
                    hi  = win_smp[ch][0];
                    for (int i = 0; i < win_len[ch]; i++) begin
                        sum += win_smp[ch][i];
                        if (win_smp[ch][i] < lo) lo = win_smp[ch][i];
                        if (win_smp[ch][i] > hi) hi = win_smp[ch][i];
                    end
                    m_avg[ch]   = sum / win_len[ch];
                    m_min[ch]   = lo;
                    m_max[ch]   = hi;
                    m_valid[ch] = 1;
                    win_len[ch] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("avg_a", avg_a_o, m_avg[0]);
        check("avg_b", avg_b_o, m_avg[1]);
        check("valid_a", avg_a_valid_o, m_valid[0]);
        check("valid_b", avg_b_valid_o, m_valid[1]);
`ifdef XADC_AVG_MINMAX_EN
        check("min_a", min_a_o, m_min[0]);
        check("max_a", max_a_o, m_max[0]);
        check("min_b", min_b_o, m_min[1]);
        check("max_b", max_b_o, m_max[1]);
`else
        check("min_a", min_a_o, 0);
        check("max_a", max_a_o, 0);
        check("min_b", min_b_o, 0);
        check("max_b", max_b_o, 0);
`endif
    endtask

    // Inputs are applied 1 ns after a rising edge; outputs are read 1 ns after the next.
    task automatic cycle();
        model_step();
        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    task automatic edge_a(input int smp);
        xadc_a_strobe_i = 1'b1;
        xadc_a_i        = DW'(smp);
        cycle();
        xadc_a_strobe_i = 1'b0;
        cycle();
    endtask

    typedef struct {
        logic          stb;
        logic [DW-1:0] smp;
        logic [2:0]    n;
        logic          clr;
        logic          exp_v;
        logic [DW-1:0] exp_avg;
    } vec_t;

    vec_t tbl [22];
    int   pulses;

    initial begin
        // Channel A: N=2 window of 100..400, then a clear on the 3rd edge, then four 8s.
        tbl[0]  = '{1'b1, 12'd100, 3'd2, 1'b0, 1'b0, 12'd0};
        tbl[1]  = '{1'b0, 12'd0,   3'd2, 1'b0, 1'b0, 12'd0};
        tbl[2]  = '{1'b1, 12'd200, 3'd2, 1'b0, 1'b0, 12'd0};
        tbl[3]  = '{1'b0, 12'd0,   3'd2, 1'b0, 1'b0, 12'd0};
        tbl[4]  = '{1'b1, 12'd300, 3'd2, 1'b0, 1'b0, 12'd0};
        tbl[5]  = '{1'b0, 12'd0,   3'd2, 1'b0, 1'b0, 12'd0};
        tbl[6]  = '{1'b1, 12'd400, 3'd2, 1'b0, 1'b1, 12'd250};
        tbl[7]  = '{1'b0, 12'd0,   3'd2, 1'b0, 1'b0, 12'd250};
        tbl[8]  = '{1'b1, 12'd10,  3'd2, 1'b0, 1'b0, 12'd250};
        tbl[9]  = '{1'b0, 12'd0,   3'd2, 1'b0, 1'b0, 12'd250};
        tbl[10] = '{1'b1, 12'd20,  3'd2, 1'b0, 1'b0, 12'd250};
        tbl[11] = '{1'b0, 12'd0,   3'd2, 1'b0, 1'b0, 12'd250};
        tbl[12] = '{1'b1, 12'd999, 3'd2, 1'b1, 1'b0, 12'd250};
        tbl[13] = '{1'b0, 12'd0,   3'd2, 1'b0, 1'b0, 12'd250};
        tbl[14] = '{1'b1, 12'd8,   3'd2, 1'b0, 1'b0, 12'd250};
        tbl[15] = '{1'b0, 12'd0,   3'd2, 1'b0, 1'b0, 12'd250};
        tbl[16] = '{1'b1, 12'd8,   3'd2, 1'b0, 1'b0, 12'd250};
        tbl[17] = '{1'b0, 12'd0,   3'd2, 1'b0, 1'b0, 12'd250};
        tbl[18] = '{1'b1, 12'd8,   3'd2, 1'b0, 1'b0, 12'd250};
        tbl[19] = '{1'b0, 12'd0,   3'd2, 1'b0, 1'b0, 12'd250};
        tbl[20] = '{1'b1, 12'd8,   3'd2, 1'b0, 1'b1, 12'd8};
        tbl[21] = '{1'b0, 12'd0,   3'd2, 1'b0, 1'b0, 12'd8};

        rstn_i          = 1'b0;
        xadc_a_i        = '0;
        xadc_b_i        = '0;
        xadc_a_strobe_i = 1'b0;
        xadc_b_strobe_i = 1'b0;
        avg_log2_i      = 3'd0;
        clear_i         = 1'b0;
        model_reset();

        repeat (2) @(posedge clk_i);
        #1;
        check("reset avg_a", avg_a_o, 0);
        check("reset avg_b", avg_b_o, 0);
        check("reset valid_a", avg_a_valid_o, 0);
        check("reset valid_b", avg_b_valid_o, 0);
        check("reset min_a", min_a_o, 0);
        check("reset max_b", max_b_o, 0);
        rstn_i = 1'b1;
        cycle();

        for (int i = 0; i < 22; i++) begin
            xadc_a_strobe_i = tbl[i].stb;
            xadc_a_i        = tbl[i].smp;
            avg_log2_i      = tbl[i].n;
            clear_i         = tbl[i].clr;
            cycle();
            check($sformatf("tbl[%0d] valid_a", i), avg_a_valid_o, tbl[i].exp_v);
            check($sformatf("tbl[%0d] avg_a", i), avg_a_o, tbl[i].exp_avg);
        end
        clear_i = 1'b0;

        // Strobe held high five cycles at N=0 counts as a single sample.
        avg_log2_i      = 3'd0;
        xadc_a_i        = 12'd4095;
        xadc_a_strobe_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            pulses += int'(avg_a_valid_o);
        end
        check("held strobe pulses", pulses, 1);
        check("held strobe avg", avg_a_o, 4095);
        xadc_a_strobe_i = 1'b0;
        cycle();

        // N=7: full-scale window must not wrap; then truncation toward zero.
        avg_log2_i = 3'd7;
        pulses = 0;
        for (int i = 0; i < 128; i++) begin
            edge_a(4095);
            pulses += int'(avg_a_valid_o);
        end
        check("n7 full avg", avg_a_o, 4095);
        for (int i = 0; i < 128; i++) begin
            xadc_a_strobe_i = 1'b1;
            xadc_a_i        = (i == 127) ? 12'd1 : 12'd0;
            cycle();
            if (i == 127) check("n7 trunc valid", avg_a_valid_o, 1);
            xadc_a_strobe_i = 1'b0;
            cycle();
        end
        check("n7 trunc avg", avg_a_o, 0);

        // Exponent change mid-window only affects the following window.
        avg_log2_i = 3'd1;
        edge_a(10);
        avg_log2_i = 3'd3;
        xadc_a_strobe_i = 1'b1;
        xadc_a_i        = 12'd30;
        cycle();
        check("exp change 2nd edge valid", avg_a_valid_o, 1);
        check("exp change avg", avg_a_o, 20);
        xadc_a_strobe_i = 1'b0;
        cycle();
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            xadc_a_strobe_i = 1'b1;
            xadc_a_i        = DW'(i * 100);
            cycle();
            pulses += int'(avg_a_valid_o);
            xadc_a_strobe_i = 1'b0;
            cycle();
        end
        check("n3 window pulses", pulses, 1);
        check("n3 window avg", avg_a_o, 450);

        // Simultaneous A and B windows at N=2.
        avg_log2_i = 3'd2;
        for (int i = 0; i < 4; i++) begin
            xadc_a_strobe_i = 1'b1;
            xadc_b_strobe_i = 1'b1;
            case (i)
                0: begin xadc_a_i = 12'd5;   xadc_b_i = 12'd4000; end
                1: begin xadc_a_i = 12'd900; xadc_b_i = 12'd1;    end
                2: begin xadc_a_i = 12'd17;  xadc_b_i = 12'd2;    end
                default: begin xadc_a_i = 12'd42; xadc_b_i = 12'd3; end
            endcase
            cycle();
            xadc_a_strobe_i = 1'b0;
            xadc_b_strobe_i = 1'b0;
            cycle();
        end
        check("dual avg_a", avg_a_o, 241);
        check("dual avg_b", avg_b_o, 1001);
`ifdef XADC_AVG_MINMAX_EN
        check("dual min_a", min_a_o, 5);
        check("dual max_a", max_a_o, 900);
        check("dual min_b", min_b_o, 1);
        check("dual max_b", max_b_o, 4000);
`endif

        // Reset mid-window with the strobe high across release.
        edge_a(50);
        edge_a(60);
        xadc_a_strobe_i = 1'b1;
        xadc_a_i        = 12'd7;
        rstn_i          = 1'b0;
        model_reset();
        #1;
        check("async reset avg_a", avg_a_o, 0);
        @(posedge clk_i);
        #1;
        check("mid reset valid_a", avg_a_valid_o, 0);
        rstn_i = 1'b1;
        cycle();
        xadc_a_strobe_i = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) edge_a(7);
        check("post reset avg", avg_a_o, 7);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            xadc_a_strobe_i = ($urandom_range(0, 2) == 0);
            xadc_b_strobe_i = ($urandom_range(0, 2) == 0);
            xadc_a_i        = DW'($urandom);
            xadc_b_i        = DW'($urandom);
            clear_i         = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 39) == 0) avg_log2_i = 3'($urandom_range(0, 4));
            cycle();
        end
        clear_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
